// File: rtl/iter_div.sv
// iter_div: radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
module iter_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              sgn,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] r, q, d;
  logic neg_q, neg_r, dz, start;
  logic [DATA_W:0] sh, t;
  assign start = run && (state == IDLE || state == DONE);
  assign busy = state == CALC || state == FIX;
  assign done = state == DONE;
  assign sh = {r, q[DATA_W-1]};
  assign t = sh - {1'b0, d};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = run ? CALC : IDLE;
      CALC: state_nx = cnt == '0 ? FIX : CALC;
      FIX:  state_nx = DONE;
      DONE: state_nx = run ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Magnitudes are kept as unsigned DATA_W-bit values, so |most-negative| needs no extra bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      out0 <= '0;
      out1 <= '0;
    end else if (start) begin
      cnt <= CW'(DATA_W - 1);
      r <= '0;
      q <= (sgn && in0[DATA_W-1]) ? -in0 : in0;
      d <= (sgn && in1[DATA_W-1]) ? -in1 : in1;
      neg_q <= sgn && (in0[DATA_W-1] ^ in1[DATA_W-1]);
      neg_r <= sgn && in0[DATA_W-1];
      dz <= in1 == '0;
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      r <= t[DATA_W] ? sh[DATA_W-1:0] : t[DATA_W-1:0];
      q <= {q[DATA_W-2:0], ~t[DATA_W]};
    end else if (state == FIX) begin
      out0 <= dz ? '1 : neg_q ? -q : q;
      out1 <= neg_r ? -r : r;
    end
  end
endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed and randomized checks of iter_div against an arithmetic reference model.
module tb_iter_div;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, run, sgn, busy, done;
  logic [W-1:0] in0, in1, out0, out1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  iter_div #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0), .in1(in1), .sgn(sgn),
    .busy(busy), .done(done), .out0(out0), .out1(out1)
  );
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction
  task automatic divide(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] eq, er;
    int n = 0;
    int nb = 0;
    model(a, b, s, eq, er);
    in0 = a;
    in1 = b;
    sgn = s;
    run = 1'b1;
    tick;
    while (!done && n < 50) begin
      if (busy) nb++;
      in0 = $urandom;
      in1 = $urandom;
      sgn = 1'($urandom_range(0, 1));
      run = (n == 5);
      tick;
      n++;
    end
    run = 1'b0;
    check("latency", n, W + 1);
    check("busy_cycles", nb, W + 1);
    check("quot", out0, eq);
    check("rem", out1, er);
    tick;
    check("done_pulse", {31'b0, done}, 0);
    check("hold_quot", out0, eq);
    check("hold_rem", out1, er);
  endtask
  initial begin
    logic [W-1:0] qa[$], qb[$], eq, er, a, b;
    logic qs[$];
    int cyc, last, got, seen;
    rst = 1'b1;
    run = 1'b0;
    sgn = 1'b0;
    in0 = '0;
    in1 = '0;
    tick;
    tick;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    rst = 1'b0;
    tick;
    divide(100, 7, 1'b0);
    divide(-100, 7, 1'b1);
    divide(100, -7, 1'b1);
    divide(32'h12345678, 0, 1'b0);
    divide(32'h12345678, 0, 1'b1);
    divide(32'h80000000, 32'hFFFFFFFF, 1'b1);
    divide(32'h80000000, 32'hFFFFFFFF, 1'b0);
    divide(32'h87654321, 0, 1'b1);
    divide(32'h80000000, 1, 1'b1);
    // back-to-back: run held high, operands change every cycle
    in0 = $urandom;
    in1 = $urandom_range(1, 1000);
    sgn = 1'($urandom_range(0, 1));
    qa.push_back(in0);
    qb.push_back(in1);
    qs.push_back(sgn);
    run = 1'b1;
    tick;
    cyc = 0;
    last = 0;
    got = 0;
    while (got < 4 && cyc < 400) begin
      cyc++;
      if (done) begin
        model(qa.pop_front(), qb.pop_front(), qs.pop_front(), eq, er);
        check("b2b_quot", out0, eq);
        check("b2b_rem", out1, er);
        if (got > 0) check("b2b_gap", cyc - last, W + 2);
        last = cyc;
        got++;
      end
      in0 = $urandom;
      in1 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (done) begin
        if (got < 4) begin
          qa.push_back(in0);
          qb.push_back(in1);
          qs.push_back(sgn);
        end else run = 1'b0;
      end
      tick;
    end
    run = 1'b0;
    check("b2b_count", got, 4);
    tick;
    // reset mid-division
    divide(1000, 3, 1'b0);
    in0 = 32'd77777;
    in1 = 32'd5;
    sgn = 1'b0;
    run = 1'b1;
    tick;
    run = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_out0", out0, 0);
    check("arst_out1", out1, 0);
    tick;
    tick;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      tick;
      if (done || busy) seen++;
    end
    check("no_done_after_rst", seen, 0);
    divide(77777, 5, 1'b0);
    for (int i = 0; i < 500; i++) begin
      a = $urandom_range(0, 9) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      divide(a, b, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
